apple1_kbd_pia: RTL and testbench
=================================

// Module: apple1_kbd_pia
// PURPOSE
//  Apple-1 keyboard port (KBD $D010 / KBDCR $D011) with type-ahead buffer. Sits between the
//  PS/2 scancode->ASCII decoder (upstream) and the 6502 data-in mux (downstream, keyboard_cs).
//  Buffers ASCII keys in a FIFO and presents one key at a time through a holding register.
//  Optional pacing between keys makes host paste into the Woz monitor reliable.
// PARAMETERS
//  DEPTH        16  FIFO entries; power of 2, >=2
//  PACE_CYCLES  0   cpu_clken ticks the port stays not-ready after each KBD read; 0 = none
// PORTS
//  sys_clock    in   1   system clock; only clock
//  reset        in   1   synchronous, active-high
//  cpu_clken    in   1   CPU clock enable; all CPU-side actions qualify on it
//  cs           in   1   keyboard chip select ($D010-$D011)
//  address      in   1   addr[0]: 0=KBD, 1=KBDCR
//  we           in   1   CPU write strobe; writes ignored
//  dout         out  8   registered read data to CPU mux
//  key_valid    in   1   one-cycle strobe: key_ascii valid
//  key_ascii    in   7   7-bit ASCII from decoder
//  key_ready    out  1   FIFO not full
//  flush        in   1   clear buffer, e.g. from clear-screen button
//  overflow     out  1   sticky: a key was dropped
//  fifo_level   out  $clog2(DEPTH+1)  entries in FIFO (holding reg excluded)
// BEHAVIOUR
//  - Reset: dout=8'h00, overflow=0, fifo_level=0, key_ready=1, state=EMPTY, hold=7'h00.
//  - Push: key_valid & !full -> write. key_valid & full -> drop, overflow<=1 (unless same-cycle
//    FIFO read frees a slot: then push accepted, level unchanged).
//  - FSM EMPTY: FIFO non-empty -> pop into hold, go HELD (1 cycle; ready visible next cycle).
//    HELD: kbd_rd -> PACE_CYCLES==0 ? EMPTY : GAP (load counter PACE_CYCLES-1).
//    GAP: decrement on cpu_clken; at 0 on cpu_clken -> EMPTY. ready = (state==HELD).
//  - kbd_rd = cpu_clken & cs & !we & address==0. Reading KBD when not HELD: no state change.
//  - dout: on cpu_clken edge, dout <= address ? {ready,7'b0} : {1'b1,hold}; when !cs or
//    !cpu_clken dout holds. Read data captured before the same edge's kbd_rd takes effect.
//  - KBD read of a held key returns {1,hold}; hold keeps last value after read.
//  - flush (and reset): FIFO emptied, state=EMPTY, counter=0, overflow=0; flush beats push
//    and kbd_rd same cycle; dout unchanged by flush.
//  - FIFO pointers wrap modulo DEPTH; level counts 0..DEPTH, full at DEPTH.
// CONFIGURATION
//  KBD_UPCASE_EN defined: key_ascii 7'h61-7'h7A stored minus 7'h20 (lower->upper); 7'h7F
//    stored as 7'h5F (Apple-1 rubout '_'). Undefined: key_ascii stored unchanged.
// STRUCTURE
//  apple1_pkg: KBD_OFS=1'b0, KBDCR_OFS=1'b1, ASCII_DEL=7'h7F, ASCII_US=7'h5F,
//    kbd_state_t enum {EMPTY,HELD,GAP}.
//  Sub-module kbd_fifo (sync FIFO, width 7, DEPTH; push/pop/full/empty/level/clear).
// TESTING
//  1 Push 'A'(7'h41); read D011 -> 8'h80; read D010 -> 8'hC1; read D011 -> 8'h00.
//  2 Push 20 keys at DEPTH=16 without reads -> 17 accepted (16 FIFO + hold), overflow=1,
//    key_ready=0; drain 17 reads returns keys in order; flush clears overflow.
//  3 PACE_CYCLES=4: after D010 read, D011 reads 8'h00 for 4 cpu_clken ticks, then 8'h80.
//  4 FIFO full, key_valid same cycle as EMPTY->HELD pop -> key accepted, overflow stays 0.
//  5 KBD_UPCASE_EN: push 7'h61 -> D010 reads 8'hC1; push 7'h7F -> 8'hDF; undefined: 8'hE1.
//  6 Reset asserted while HELD with 5 in FIFO -> next cycle fifo_level=0, dout=8'h00,
//    D011 reads 8'h00; write to D010/D011 leaves state and FIFO unchanged.

Source files
------------

// File: rtl/apple1_pkg.sv
// Shared constants, state encoding and key mapping for the Apple-1 keyboard port.
// Defining KBD_UPCASE_EN folds lower case to upper case and maps DEL to the Apple-1 rubout '_'.
package apple1_pkg;

    localparam logic       KBD_OFS   = 1'b0;
    localparam logic       KBDCR_OFS = 1'b1;
    localparam logic [6:0] ASCII_DEL = 7'h7F;
    localparam logic [6:0] ASCII_US  = 7'h5F;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HELD  = 2'd1,
        GAP   = 2'd2
    } kbd_state_t;

    function automatic logic [6:0] kbd_map(input logic [6:0] key);
        logic [6:0] res;
        res = key;
`ifdef KBD_UPCASE_EN
        if (key >= 7'h61 && key <= 7'h7A)
            res = key - 7'h20;
        else if (key == ASCII_DEL)
            res = ASCII_US;
`endif
        return res;
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous FIFO with combinational head output; level is 0..DEPTH.
// A push while full is taken only when a pop frees a slot in the same cycle.
module kbd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 7
) (
    input  logic                       sys_clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);

    always_ff @(posedge sys_clock) begin
        if (do_push && !clear)
            mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge sys_clock) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/apple1_kbd_pia.sv
// Apple-1 KBD/KBDCR port: buffers decoder keys, presents one at a time via a holding register.
// dout registered on the cpu_clken edge; key_ready low when the FIFO is full, excess keys set overflow.
module apple1_kbd_pia
    import apple1_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int PACE_CYCLES = 0
) (
    input  logic                       sys_clock,
    input  logic                       reset,
    input  logic                       cpu_clken,
    input  logic                       cs,
    input  logic                       address,
    input  logic                       we,
    output logic [7:0]                 dout,
    input  logic                       key_valid,
    input  logic [6:0]                 key_ascii,
    output logic                       key_ready,
    input  logic                       flush,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

    localparam int CW = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;

    kbd_state_t state;
    logic [6:0]    hold;
    logic [CW-1:0] pace_cnt;
    logic [6:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          kbd_rd;
    logic          ready;

    assign kbd_rd    = cpu_clken & cs & !we & (address == KBD_OFS);
    assign ready     = (state == HELD);
    assign fifo_pop  = (state == EMPTY) & !fifo_empty & !flush;
    assign key_ready = !fifo_full;

    kbd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (7)
    ) u_fifo (
        .sys_clock (sys_clock),
        .reset     (reset),
        .clear     (flush),
        .push      (key_valid & !flush),
        .pop       (fifo_pop),
        .din       (kbd_map(key_ascii)),
        .dout      (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge sys_clock) begin
        if (reset || flush) begin
            state    <= EMPTY;
            pace_cnt <= '0;
        end else begin
            case (state)
                EMPTY: if (!fifo_empty) state <= HELD;
                HELD: begin
                    if (kbd_rd) begin
                        if (PACE_CYCLES == 0) begin
                            state <= EMPTY;
                        end else begin
                            state    <= GAP;
                            pace_cnt <= CW'(PACE_CYCLES - 1);
                        end
                    end
                end
                GAP: begin
                    if (cpu_clken) begin
                        if (pace_cnt == '0)
                            state <= EMPTY;
                        else
                            pace_cnt <= pace_cnt - CW'(1);
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge sys_clock) begin
        if (reset)
            hold <= 7'h00;
        else if (fifo_pop)
            hold <= fifo_dout;
    end

    // Read data reflects the state before this edge's KBD read retires the key.
    always_ff @(posedge sys_clock) begin
        if (reset)
            dout <= 8'h00;
        else if (cpu_clken && cs)
            dout <= (address == KBDCR_OFS) ? {ready, 7'b0} : {1'b1, hold};
    end

    always_ff @(posedge sys_clock) begin
        if (reset || flush)
            overflow <= 1'b0;
        else if (key_valid && fifo_full && !fifo_pop)
            overflow <= 1'b1;
    end

endmodule

// File: tb/tb_apple1_kbd_pia.sv
// Bench for apple1_kbd_pia: a default-pacing and a PACE_CYCLES=4 instance share one stimulus stream.
module tb_apple1_kbd_pia;

    localparam int DEPTH = 16;

    logic       sys_clock = 1'b0;
    logic       reset, cpu_clken, cs, address, we, key_valid, flush;
    logic [6:0] key_ascii;
    logic [7:0] dout0, dout4;
    logic       krdy0, krdy4, ovf0, ovf4;
    logic [4:0] lvl0, lvl4;

    int total = 0;
    int bad   = 0;

    always #5 sys_clock = ~sys_clock;

    apple1_kbd_pia #(.DEPTH(DEPTH), .PACE_CYCLES(0)) dut0 (
        .sys_clock(sys_clock), .reset(reset), .cpu_clken(cpu_clken), .cs(cs),
        .address(address), .we(we), .dout(dout0), .key_valid(key_valid),
        .key_ascii(key_ascii), .key_ready(krdy0), .flush(flush),
        .overflow(ovf0), .fifo_level(lvl0)
    );

    apple1_kbd_pia #(.DEPTH(DEPTH), .PACE_CYCLES(4)) dut4 (
        .sys_clock(sys_clock), .reset(reset), .cpu_clken(cpu_clken), .cs(cs),
        .address(address), .we(we), .dout(dout4), .key_valid(key_valid),
        .key_ascii(key_ascii), .key_ready(krdy4), .flush(flush),
        .overflow(ovf4), .fifo_level(lvl4)
    );

    typedef struct {
        int         op;   // 0 push, 1 read KBD, 2 read KBDCR, 3 expect level
        logic [6:0] key;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int op, input logic [6:0] key, input logic [7:0] exp);
        vec_t v;
        v.op = op; v.key = key; v.exp = exp;
        return v;
    endfunction

    function automatic logic [6:0] conv(input logic [6:0] k);
`ifdef KBD_UPCASE_EN
        if (k >= 7'h61 && k <= 7'h7A) return k - 7'h20;
        if (k == 7'h7F) return 7'h5F;
`endif
        return k;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clock);
        #1;
    endtask

    // One CPU access: a single cpu_clken cycle followed by three idle system cycles.
    task automatic cpu_acc(input logic a, input logic w, output logic [7:0] d0, output logic [7:0] d4);
        cpu_clken = 1'b1; cs = 1'b1; address = a; we = w;
        tick();
        d0 = dout0; d4 = dout4;
        cpu_clken = 1'b0; cs = 1'b0; we = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic push_key(input logic [6:0] k);
        key_valid = 1'b1; key_ascii = k;
        tick();
        key_valid = 1'b0;
        tick(); tick();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] d0, d4;
        logic [6:0] buf_q[$];
        logic [6:0] last_held;
        logic       m_ovf;
        logic [6:0] k;
        int         r;
        logic       do_push;

        reset = 1'b1; cpu_clken = 1'b0; cs = 1'b0; address = 1'b0; we = 1'b0;
        key_valid = 1'b0; key_ascii = 7'h00; flush = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;

        check("rst_dout", dout0, 8'h00);
        check("rst_ovf", {ovf4, ovf0}, 2'b00);
        check("rst_level", {lvl4, lvl0}, 10'd0);
        check("rst_key_ready", {krdy4, krdy0}, 2'b11);
        cpu_acc(1'b1, 1'b0, d0, d4);
        check("rst_kbdcr", d0, 8'h00);
        cpu_acc(1'b0, 1'b0, d0, d4);
        check("rst_kbd_hold", d0, 8'h80);

        // Basic ordering, hold-after-read and character mapping.
        tbl.push_back(mk(0, 7'h41, 8'h00));
        tbl.push_back(mk(2, 7'h00, 8'h80));
        tbl.push_back(mk(1, 7'h00, 8'hC1));
        tbl.push_back(mk(2, 7'h00, 8'h00));
        tbl.push_back(mk(1, 7'h00, 8'hC1));
        tbl.push_back(mk(0, 7'h61, 8'h00));
        tbl.push_back(mk(1, 7'h00, {1'b1, conv(7'h61)}));
        tbl.push_back(mk(0, 7'h7F, 8'h00));
        tbl.push_back(mk(1, 7'h00, {1'b1, conv(7'h7F)}));
        tbl.push_back(mk(0, 7'h7A, 8'h00));
        tbl.push_back(mk(1, 7'h00, {1'b1, conv(7'h7A)}));
        tbl.push_back(mk(0, 7'h60, 8'h00));
        tbl.push_back(mk(1, 7'h00, 8'hE0));
        tbl.push_back(mk(0, 7'h7B, 8'h00));
        tbl.push_back(mk(1, 7'h00, 8'hFB));
        tbl.push_back(mk(0, 7'h31, 8'h00));
        tbl.push_back(mk(0, 7'h32, 8'h00));
        tbl.push_back(mk(3, 7'h00, 8'd1));
        tbl.push_back(mk(1, 7'h00, 8'hB1));
        tbl.push_back(mk(3, 7'h00, 8'd0));
        tbl.push_back(mk(1, 7'h00, 8'hB2));
        tbl.push_back(mk(2, 7'h00, 8'h00));

        for (int i = 0; i < tbl.size(); i++) begin
            case (tbl[i].op)
                0: push_key(tbl[i].key);
                1: begin cpu_acc(1'b0, 1'b0, d0, d4); check($sformatf("tbl%0d_kbd", i), d0, tbl[i].exp); end
                2: begin cpu_acc(1'b1, 1'b0, d0, d4); check($sformatf("tbl%0d_kbdcr", i), d0, tbl[i].exp); end
                default: check($sformatf("tbl%0d_level", i), lvl0, tbl[i].exp[4:0]);
            endcase
        end

        // Overflow: 20 pushes, 17 retained.
        do_flush();
        for (int i = 0; i < 20; i++) push_key(7'(7'h30 + i));
        check("ovf_set", ovf0, 1'b1);
        check("ovf_key_ready", krdy0, 1'b0);
        check("ovf_level", lvl0, 5'd16);
        for (int i = 0; i < 17; i++) begin
            cpu_acc(1'b0, 1'b0, d0, d4);
            check($sformatf("drain%0d", i), d0, {1'b1, 7'(7'h30 + i)});
        end
        cpu_acc(1'b1, 1'b0, d0, d4);
        check("drain_empty_cr", d0, 8'h00);
        check("ovf_sticky", ovf0, 1'b1);
        do_flush();
        check("flush_ovf", ovf0, 1'b0);
        check("flush_ready", krdy0, 1'b1);

        // Full FIFO with a push in the same cycle as the EMPTY->HELD pop.
        for (int i = 0; i < 17; i++) push_key(7'(7'h40 + i));
        check("full_level", lvl0, 5'd16);
        check("full_key_ready", krdy0, 1'b0);
        cpu_clken = 1'b1; cs = 1'b1; address = 1'b0; we = 1'b0;
        tick();
        cpu_clken = 1'b0; cs = 1'b0;
        key_valid = 1'b1; key_ascii = 7'h55;
        tick();
        key_valid = 1'b0;
        check("poppush_dout", dout0, 8'hC0);
        check("poppush_ovf", ovf0, 1'b0);
        check("poppush_level", lvl0, 5'd16);
        tick(); tick();
        for (int i = 1; i < 18; i++) begin
            cpu_acc(1'b0, 1'b0, d0, d4);
            check($sformatf("popdrain%0d", i), d0, (i == 17) ? 8'hD5 : {1'b1, 7'(7'h40 + i)});
        end

        // Pacing: PACE_CYCLES=4 instance stays not-ready for four cpu_clken ticks.
        do_flush();
        push_key(7'h41);
        push_key(7'h42);
        cpu_acc(1'b1, 1'b0, d0, d4);
        check("pace_cr_before", d4, 8'h80);
        cpu_acc(1'b0, 1'b0, d0, d4);
        check("pace_kbd", d4, 8'hC1);
        for (int i = 0; i < 4; i++) begin
            cpu_acc(1'b1, 1'b0, d0, d4);
            check($sformatf("pace_gap%0d", i), d4, 8'h00);
            if (i == 0) check("nopace_cr", d0, 8'h80);
        end
        cpu_acc(1'b1, 1'b0, d0, d4);
        check("pace_cr_after", d4, 8'h80);
        cpu_acc(1'b0, 1'b0, d0, d4);
        check("pace_kbd2", d4, 8'hC2);

        // Writes ignored; reset while HELD with five queued.
        do_flush();
        for (int i = 0; i < 6; i++) push_key(7'(7'h50 + i));
        check("pre_rst_level", lvl0, 5'd5);
        cpu_acc(1'b0, 1'b1, d0, d4);
        cpu_acc(1'b1, 1'b1, d0, d4);
        check("wr_level", lvl0, 5'd5);
        cpu_acc(1'b1, 1'b0, d0, d4);
        check("wr_state_held", d0, 8'h80);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_level", lvl0, 5'd0);
        check("rst2_dout", dout0, 8'h00);
        check("rst2_ready", krdy0, 1'b1);
        cpu_acc(1'b1, 1'b0, d0, d4);
        check("rst2_kbdcr", d0, 8'h00);

        // Random traffic against a queue model of everything buffered (hold + FIFO).
        do_flush();
        push_key(7'h20);
        cpu_acc(1'b0, 1'b0, d0, d4);
        last_held = 7'h20;
        m_ovf = 1'b0;
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if ((it < 200 && r < 20) || (it >= 200 && r < 55)) begin
                cpu_clken = 1'b1; cs = 1'b1; address = 1'b0; we = 1'b0;
            end else if (r < 70) begin
                cpu_clken = 1'b1; cs = 1'b1; address = 1'b1; we = 1'b0;
            end else if (r < 85) begin
                cpu_clken = 1'b1; cs = 1'b1; address = r[0]; we = 1'b1;
            end else begin
                cpu_clken = 1'b1; cs = 1'b0; address = 1'b0; we = 1'b0;
            end
            tick();
            if (cs && !we) begin
                if (address == 1'b1) begin
                    check("rnd_kbdcr", dout0, {buf_q.size() > 0, 7'b0});
                end else if (buf_q.size() > 0) begin
                    check("rnd_kbd", dout0, {1'b1, buf_q[0]});
                    void'(buf_q.pop_front());
                    if (buf_q.size() > 0) last_held = buf_q[0];
                end else begin
                    check("rnd_kbd_idle", dout0, {1'b1, last_held});
                end
            end
            cpu_clken = 1'b0; cs = 1'b0; we = 1'b0;
            tick();
            do_push = ($urandom_range(0, 99) < 65);
            k = 7'($urandom_range(0, 127));
            key_valid = do_push; key_ascii = k;
            tick();
            key_valid = 1'b0;
            if (do_push) begin
                if (buf_q.size() < DEPTH + 1) begin
                    buf_q.push_back(conv(k));
                    if (buf_q.size() == 1) last_held = buf_q[0];
                end else begin
                    m_ovf = 1'b1;
                end
            end
            tick();
            check("rnd_level", lvl0, (buf_q.size() > 0) ? 5'(buf_q.size() - 1) : 5'd0);
            check("rnd_ovf", ovf0, m_ovf);
            check("rnd_key_ready", krdy0, buf_q.size() < DEPTH + 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
